sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port synchronous SRAM (1-cycle registered read, read-old-data on write).
- Shares the SRAM between requesters A and B using round-robin arbitration with valid/ready handshakes.
- Supports single writes, single reads and auto-incrementing read bursts.
- Returns read data to the owning requester with a response valid and a last flag.

Parameters:
DWIDTH, 32, SRAM data width.
AWIDTH, 8, SRAM address width; address space 2**AWIDTH words.
LWIDTH, 4, burst length field width; a burst is len+1 beats, max 2**LWIDTH.

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
a_req_valid  in  1  A request valid
a_req_ready  out  1  A request accepted this cycle
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  AWIDTH  start address
a_req_wdata  in  DWIDTH  write data
a_req_len  in  LWIDTH  read beats minus 1; ignored for writes
a_rsp_valid  out  1  read data valid for A
a_rsp_last  out  1  final beat of A's read
a_rsp_data  out  DWIDTH  read data
b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_req_len, b_rsp_valid, b_rsp_last, b_rsp_data  same as A, for requester B
sram_we  out  1  SRAM write enable
sram_addr  out  AWIDTH  SRAM address
sram_wdata  out  DWIDTH  SRAM write data
sram_rdata  in  DWIDTH  SRAM registered read data
busy  out  1  burst in progress

Behaviour:
- Clocking and reset: clk only; reset is synchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE; rr_pref = A.
  - Response pipeline register cleared, so both rsp_valid = 0 and both rsp_last = 0.
  - busy = 0, both req_ready = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
- FSM states: IDLE and BURST. busy = (state == BURST).
- IDLE arbitration (combinational, each cycle):
  - Only one valid: grant it.
  - Both valid: grant rr_pref.
  - On grant, the granted req_ready = 1 and the other = 0.
  - On acceptance, rr_pref becomes the non-granted requester.
  - No valid: both ready = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
- Issue on acceptance: sram_we/addr/wdata are driven combinationally from the granted request in the same cycle.
  - Write: one cycle; stays IDLE; no response generated. SRAM read-old data for that cycle is discarded.
  - Read, len = 0: single beat; stays IDLE.
  - Read, len > 0: beat 0 issued; go to BURST with owner latched, cur_addr = addr+1, remaining = len.
- BURST:
  - Both req_ready = 0, sram_we = 0, sram_addr = cur_addr.
  - Each cycle: issue one beat, cur_addr += 1, remaining -= 1.
  - Beat issued with remaining == 1 is the last; next state IDLE.
  - Total beats = len+1 on consecutive cycles, no bubbles.
- Address arithmetic: modulo 2**AWIDTH; 2**AWIDTH-1 wraps to 0.
- Response: registered issue_valid/owner/last from the issue cycle.
  - rsp_valid of the owner = 1 exactly one cycle after each read beat is issued. rsp_last = 1 on the final beat only (len = 0 read: last = 1).
  - Non-owner rsp_valid = 0.
  - a_rsp_data and b_rsp_data = sram_rdata at all times (content valid only with rsp_valid).
- Back-to-back behaviour:
  - New acceptance is possible in the cycle after a burst's final beat.
  - A read issued the cycle after a write to the same address returns the new data.
  - A response from the previous issue may coincide with any new issue.
- Requester rule: payload must be held stable while valid && !ready. Arbitration is re-evaluated every cycle.
- Reset mid-burst: next cycle is IDLE, busy = 0, no further beats. No rsp_valid in the cycle after the reset edge, including the in-flight beat.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, all req_valid = 1 -> during reset and the cycle after, rsp_valid = 0, busy = 0. Both req_ready = 0 while rst_n = 0.
- Write then read: A writes 0xDEADBEEF to 0x10; next cycle A reads 0x10 with len = 0 -> a_rsp_valid = 1 and a_rsp_last = 1 one cycle after accept, a_rsp_data = 0xDEADBEEF, b_rsp_valid = 0, no response for the write.
- Fairness: from reset, A and B hold continuous len = 0 reads -> grants A, B, A, B on consecutive cycles, never both ready in one cycle.
- Burst with wrap: B reads 0xFE with len = 3 while A requests -> sram_addr 0xFE, 0xFF, 0x00, 0x01 on 4 cycles; busy = 1 for 3 cycles; a_req_ready = 0 throughout; b_rsp_valid for 4 cycles with last on the 4th; A accepted the cycle after the 0x01 beat.
- Write ignores len: A write with len = 5 -> single cycle, sram_we = 1 for 1 cycle, busy stays 0.
- Reset mid-burst: A reads with len = 7; rst_n = 0 during the 3rd beat -> next cycle busy = 0, a_rsp_valid = 0, no further sram_addr increments.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and burst sequencer sharing one single-port SRAM between two requesters
module sram_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [AWIDTH-1:0] a_req_addr,
    input  logic [DWIDTH-1:0] a_req_wdata,
    input  logic [LWIDTH-1:0] a_req_len,
    output logic              a_rsp_valid,
    output logic              a_rsp_last,
    output logic [DWIDTH-1:0] a_rsp_data,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [AWIDTH-1:0] b_req_addr,
    input  logic [DWIDTH-1:0] b_req_wdata,
    input  logic [LWIDTH-1:0] b_req_len,
    output logic              b_rsp_valid,
    output logic              b_rsp_last,
    output logic [DWIDTH-1:0] b_rsp_data,
    output logic              sram_we,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_wdata,
    input  logic [DWIDTH-1:0] sram_rdata,
    output logic              busy
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic rr_pref, owner, grant_b, acc, issue, last, req_we;
    logic rsp_v, rsp_own, rsp_last;
    logic [AWIDTH-1:0] cur_addr, req_addr;
    logic [LWIDTH-1:0] remaining, req_len;
    logic [DWIDTH-1:0] req_wdata;

    assign busy = (state == BURST);

    // Combinational outputs are forced idle while reset is asserted
    always_comb begin
        grant_b     = b_req_valid && (!a_req_valid || rr_pref);
        acc         = rst_n && !busy && (a_req_valid || b_req_valid);
        a_req_ready = acc && !grant_b;
        b_req_ready = acc && grant_b;
        req_we      = grant_b ? b_req_we : a_req_we;
        req_addr    = grant_b ? b_req_addr : a_req_addr;
        req_wdata   = grant_b ? b_req_wdata : a_req_wdata;
        req_len     = grant_b ? b_req_len : a_req_len;
        issue       = busy ? rst_n : acc && !req_we;
        last        = busy ? (remaining == LWIDTH'(1)) : (req_len == '0);
        sram_we     = acc && req_we;
        sram_addr   = acc ? req_addr : (busy && rst_n) ? cur_addr : '0;
        sram_wdata  = acc ? req_wdata : '0;
        state_nxt   = busy ? (last ? IDLE : BURST) : ((issue && !last) ? BURST : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_pref   <= 1'b0;
            owner     <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            rsp_v     <= 1'b0;
            rsp_own   <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            rsp_v    <= issue;
            rsp_own  <= busy ? owner : grant_b;
            rsp_last <= last;
            if (acc) begin
                rr_pref   <= !grant_b;
                owner     <= grant_b;
                cur_addr  <= req_addr + 1'b1;
                remaining <= req_len;
            end else if (busy) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    assign a_rsp_valid = rsp_v && !rsp_own;
    assign b_rsp_valid = rsp_v && rsp_own;
    assign a_rsp_last  = a_rsp_valid && rsp_last;
    assign b_rsp_last  = b_rsp_valid && rsp_last;
    assign a_rsp_data  = sram_rdata;
    assign b_rsp_data  = sram_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random and directed stimulus checked against a transaction-level arbiter/memory model
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_last;
    logic [7:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_data;
    logic [3:0]  a_req_len;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_last;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_data;
    logic [3:0]  b_req_len;
    logic        sram_we, busy;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          vectors = 0, errors = 0;
    int          left = 0;
    logic        pref = 1'b0, bown = 1'b0, reg_ok = 1'b0;
    logic [7:0]  baddr = 8'd0;
    logic        ev = 1'b0, eo = 1'b0, el = 1'b0, acc_a = 1'b0, acc_b = 1'b0;
    logic [31:0] ed = 32'd0;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_len(a_req_len),
        .a_rsp_valid(a_rsp_valid), .a_rsp_last(a_rsp_last), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_len(b_req_len),
        .b_rsp_valid(b_rsp_valid), .b_rsp_last(b_rsp_last), .b_rsp_data(b_rsp_data),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: registered read returning old data on a write
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic we, input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] ln);
        a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd; a_req_len = ln;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] ln);
        b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd; b_req_len = ln;
    endtask

    task automatic rnd(output logic v, output logic we, output logic [7:0] ad, output logic [31:0] wd, output logic [3:0] ln);
        v  = $urandom_range(0, 9) < 6;
        we = $urandom_range(0, 2) == 0;
        ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 15));
        wd = $urandom;
        ln = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
    endtask

    // One clock: check outputs against the model, advance the model, then clock
    task automatic cycle();
        logic g, gwe, e_ar, e_br, e_we, nv, no, nl;
        logic [7:0] ga, e_addr;
        logic [31:0] gwd, nd, e_wd;
        logic [3:0] gl;
        #1;
        if (reg_ok) begin
            check("a_rsp_valid", a_rsp_valid, ev && !eo);
            check("b_rsp_valid", b_rsp_valid, ev && eo);
            check("a_rsp_last", a_rsp_last, ev && !eo && el);
            check("b_rsp_last", b_rsp_last, ev && eo && el);
            if (ev) check("rsp_data", eo ? b_rsp_data : a_rsp_data, ed);
            if (rst_n) check("busy", busy, left > 0);
        end
        {e_ar, e_br, e_we, nv, no, nl} = '0;
        e_addr = 8'd0; nd = 32'd0; e_wd = 32'd0;
        if (!rst_n) begin
            left = 0; pref = 1'b0;
        end else if (left > 0) begin
            e_addr = baddr; nv = 1'b1; no = bown; nd = ref_mem[baddr]; nl = (left == 1);
            baddr = baddr + 8'd1; left--;
        end else if (a_req_valid || b_req_valid) begin
            g   = (a_req_valid && b_req_valid) ? pref : !a_req_valid;
            gwe = g ? b_req_we : a_req_we;
            ga  = g ? b_req_addr : a_req_addr;
            gwd = g ? b_req_wdata : a_req_wdata;
            gl  = g ? b_req_len : a_req_len;
            e_ar = !g; e_br = g; pref = !g; e_addr = ga; e_we = gwe; e_wd = gwd;
            if (gwe) ref_mem[ga] = gwd;
            else begin
                nv = 1'b1; no = g; nd = ref_mem[ga]; nl = (gl == 4'd0);
                left = gl; baddr = ga + 8'd1; bown = g;
            end
        end
        check("a_req_ready", a_req_ready, e_ar);
        check("b_req_ready", b_req_ready, e_br);
        check("sram_we", sram_we, e_we);
        check("sram_addr", sram_addr, e_addr);
        if (e_we) check("sram_wdata", sram_wdata, e_wd);
        acc_a = e_ar; acc_b = e_br;
        ev = nv; eo = no; el = nl; ed = nd; reg_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0;
        set_a(1, 0, 8'h00, 0, 0);
        set_b(1, 0, 8'h01, 0, 0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        cycle();
        set_a(1, 1, 8'h10, 32'hDEADBEEF, 0);
        cycle();
        set_a(1, 0, 8'h10, 0, 0);
        cycle();
        set_a(0, 0, 0, 0, 0);
        check("wr_rd_valid", a_rsp_valid, 1'b1);
        check("wr_rd_data", a_rsp_data, 32'hDEADBEEF);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_a(1, 0, 8'h01, 0, 0);
        set_b(1, 0, 8'h02, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 0, 8'hFE, 0, 3);
        cycle();
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 8'h20, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        set_a(1, 1, 8'h30, 32'h12345678, 5);
        cycle();
        set_a(0, 0, 0, 0, 0);
        check("wr_len_busy", busy, 1'b0);
        cycle();
        set_a(1, 0, 8'h40, 0, 7);
        cycle();
        set_a(0, 0, 0, 0, 0);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rsp", a_rsp_valid, 1'b0);
        cycle();
        cycle();
        for (int n = 0; n < 3000; n++) begin
            rst_n = $urandom_range(0, 199) != 0;
            if (!a_req_valid || acc_a) rnd(a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_len);
            if (!b_req_valid || acc_b) rnd(b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_len);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
